// File: rtl/ser_sched_pkg.sv
// ser_sched_pkg: frame state encoding and default frame words shared by the scheduler
package ser_sched_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHK} state_t;
  localparam logic [31:0] SYNC_DEF = 32'hA5A5_5A5A;
  localparam logic [31:0] IDLE_DEF = 32'h0000_0000;
  localparam logic [31:0] FILL_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/ser_rr_arbiter.sv
// ser_rr_arbiter: combinational round-robin pick, searching upward from the slot after ptr
module ser_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] j;
  assign any = |req;
  // Scanning farthest-first lets the nearest requester overwrite and win
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        idx = j;
        gnt = NUM_REQ'(1) << j;
      end
    end
  end
endmodule

// File: rtl/ser_frame_scheduler.sv
// ser_frame_scheduler: round-robin framer presenting SYNC, payload and optional checksum words to the serializer.
// Define SER_SCHED_CHKSUM_EN to append an XOR checksum word after each frame's payload.
module ser_frame_scheduler import ser_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W = 32,
  parameter int FRAME_LEN = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_DEF,
  parameter logic [WORD_W-1:0] FILL_WORD = FILL_DEF
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*WORD_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [WORD_W-1:0]         ser_data_o,
  input  logic                      ser_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      frame_start_o,
  output logic                      underrun_o,
  output logic                      busy_o
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] chk, chk_n, data_n, g_data, word;
  logic [NUM_REQ-1:0] grant_n, arb_gnt;
  logic [IW-1:0] ptr, ptr_n, arb_idx;
  logic arb_any, g_valid, last, load, decide, fs_n, ur_n;
  ser_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) g_data |= grant_o[i] ? req_data_i[i*WORD_W +: WORD_W] : '0;
  end
  assign g_valid = |(req_valid_i & grant_o);
  assign word = g_valid ? g_data : FILL_WORD;
  assign last = cnt == CW'(FRAME_LEN);
  assign busy_o = state != IDLE;
  assign req_ready_o = grant_o & {NUM_REQ{ser_ready_i & (state == SYNC | (state == PAYLOAD & !last))}};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    chk_n = chk;
    data_n = ser_data_o;
    grant_n = grant_o;
    ptr_n = ptr;
    fs_n = 1'b0;
    ur_n = 1'b0;
    load = 1'b0;
    decide = 1'b0;
    if (ser_ready_i)
      case (state)
        IDLE: decide = 1'b1;
        SYNC: load = 1'b1;
`ifdef SER_SCHED_CHKSUM_EN
        PAYLOAD: if (last) begin
          state_n = CHK;
          data_n = chk;
        end else load = 1'b1;
`else
        PAYLOAD: if (last) decide = 1'b1; else load = 1'b1;
`endif
        default: decide = 1'b1;
      endcase
    // An underrunning owner still gets a full-length frame, padded with FILL_WORD
    if (load) begin
      state_n = PAYLOAD;
      data_n = word;
      ur_n = !g_valid;
      cnt_n = state == SYNC ? CW'(1) : cnt + 1'b1;
      chk_n = state == SYNC ? word : chk ^ word;
    end
    if (decide) begin
      state_n = arb_any ? SYNC : IDLE;
      data_n = arb_any ? SYNC_WORD : IDLE_WORD;
      grant_n = arb_gnt;
      ptr_n = arb_any ? arb_idx : ptr;
      fs_n = arb_any;
    end
  end
  always_ff @(posedge clk_i)
    if (!reset_ni) begin
      state <= IDLE;
      ser_data_o <= IDLE_WORD;
      grant_o <= '0;
      cnt <= '0;
      chk <= '0;
      ptr <= IW'(NUM_REQ - 1);
      frame_start_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state <= state_n;
      ser_data_o <= data_n;
      grant_o <= grant_n;
      cnt <= cnt_n;
      chk <= chk_n;
      ptr <= ptr_n;
      frame_start_o <= fs_n;
      underrun_o <= ur_n;
    end
endmodule

// File: tb/tb_ser_frame_scheduler.sv
// tb_ser_frame_scheduler: directed and random stimulus against a frame-position reference model
module tb_ser_frame_scheduler;
  localparam int N = 4, W = 32, FL = 4;
`ifdef SER_SCHED_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [W-1:0] SYNC = 32'hA5A5_5A5A, FILL = 32'hDEAD_BEEF;
  logic clk_i = 1'b0, reset_ni = 1'b0, ser_ready_i = 1'b0;
  logic [N-1:0] req_valid_i = '0, req_ready_o, grant_o;
  logic [N*W-1:0] req_data_i = '0;
  logic [W-1:0] ser_data_o;
  logic frame_start_o, underrun_o, busy_o;
  int n_vec = 0, n_err = 0, rdy_cnt = 0, ur_cnt = 0, idle_cnt, last_fs;
  logic [W-1:0] src [N];
  bit vld [N];
  // Model: m_pos 0 idle, 1 sync shown, 1+k payload word k shown, FL+2 checksum shown
  int m_pos, m_own, m_ptr;
  logic [W-1:0] m_word, m_chk;
  bit m_fs, m_ur;
  logic [W-1:0] consumed [$], e [$];
  logic [N-1:0] gq [$];
  always #5 clk_i = ~clk_i;
  ser_frame_scheduler #(.NUM_REQ(N), .WORD_W(W), .FRAME_LEN(FL)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .ser_data_o(ser_data_o),
    .ser_ready_i(ser_ready_i),
    .grant_o(grant_o),
    .frame_start_o(frame_start_o),
    .underrun_o(underrun_o),
    .busy_o(busy_o)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_edge(input bit sr, input bit rn);
    logic [W-1:0] w;
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (!rn) begin
      m_pos = 0; m_own = -1; m_ptr = N - 1; m_word = '0; m_chk = '0;
      return;
    end
    if (!sr) return;
    if (m_pos == 0 || m_pos == FL + 1 + int'(CHK)) begin
      m_own = -1;
      for (int k = 1; k <= N && m_own < 0; k++) if (vld[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      m_fs = m_own >= 0;
      m_pos = m_fs ? 1 : 0;
      m_word = m_fs ? SYNC : '0;
      if (m_fs) m_ptr = m_own;
    end else if (m_pos == FL + 1) begin
      m_pos++;
      m_word = m_chk;
    end else begin
      w = vld[m_own] ? src[m_own] : FILL;
      m_ur = !vld[m_own];
      if (vld[m_own]) src[m_own]++;
      m_chk = m_pos == 1 ? w : m_chk ^ w;
      m_word = w;
      m_pos++;
    end
  endtask
  task automatic step(input bit sr, input bit rn = 1'b1);
    ser_ready_i = sr;
    reset_ni = rn;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = vld[i];
      req_data_i[i*W +: W] = src[i];
    end
    #1;
    if (rn) check("req_ready", req_ready_o, (sr && m_pos >= 1 && m_pos <= FL) ? 1 << m_own : 0);
    if (sr) consumed.push_back(ser_data_o);
    rdy_cnt += $countones(req_ready_o);
    model_edge(sr, rn);
    @(posedge clk_i);
    #1;
    check("ser_data", ser_data_o, m_word);
    check("grant", grant_o, m_own < 0 ? 0 : 1 << m_own);
    check("frame_start", frame_start_o, m_fs);
    check("underrun", underrun_o, m_ur);
    check("busy", busy_o, m_pos != 0);
    ur_cnt += underrun_o;
    @(negedge clk_i);
  endtask
  task automatic rst();
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    consumed.delete();
    rdy_cnt = 0;
    ur_cnt = 0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      src[i] = 32'(i * 16);
      vld[i] = 1'b0;
    end
    // Reset state
    rst();
    check("t1_data", ser_data_o, 0);
    check("t1_grant", grant_o, 0);
    check("t1_ready", req_ready_o, 0);
    check("t1_busy", busy_o, 0);
    // Single requester, strobe every 4th cycle
    src[1] = 1;
    for (int c = 0; c < 32; c++) begin
      vld[1] = src[1] <= 4;
      step(c % 4 == 3);
    end
    e = '{32'h0, SYNC, 32'h1, 32'h2, 32'h3, 32'h4};
    if (CHK) e.push_back(32'h4);
    while (e.size() < 8) e.push_back(32'h0);
    for (int i = 0; i < 8; i++) check($sformatf("t2_word%0d", i), consumed[i], e[i]);
    check("t2_ready_pulses", rdy_cnt, 4);
    // All requesters valid: rotating grants, no idle gap
    rst();
    for (int i = 0; i < N; i++) vld[i] = 1'b1;
    idle_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1);
      if (frame_start_o) gq.push_back(grant_o);
      if (!busy_o) idle_cnt++;
    end
    e = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    for (int i = 0; i < 5; i++) check($sformatf("t3_grant%0d", i), i < gq.size() ? 32'(gq[i]) : 32'hx, e[i]);
    check("t3_no_idle", idle_cnt, 0);
    // Requester 2 underruns after two words
    rst();
    src[2] = 100;
    for (int c = 0; c < 10; c++) begin
      vld[2] = src[2] < 102;
      step(1'b1);
    end
    check("t4_w1", consumed[2], 100);
    check("t4_w2", consumed[3], 101);
    check("t4_fill3", consumed[4], FILL);
    check("t4_fill4", consumed[5], FILL);
    check("t4_after", consumed[6], CHK ? 32'(100 ^ 101) : 32'h0);
    check("t4_underruns", ur_cnt, 2);
    // Reset truncates a frame mid-payload, then requester 0 wins first
    rst();
    vld[0] = 1'b1;
    for (int c = 0; c < 3; c++) step(1'b1);
    vld[3] = 1'b1;
    step(1'b1, 1'b0);
    check("t5_data", ser_data_o, 0);
    check("t5_grant", grant_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_ready", req_ready_o, 0);
    step(1'b1);
    check("t5_regrant", grant_o, 4'b0001);
    // Back-to-back frame period with strobe stuck high
    rst();
    vld[0] = 1'b1;
    last_fs = -1;
    for (int c = 0; c < 20; c++) begin
      step(1'b1);
      if (frame_start_o) begin
        if (last_fs >= 0) check("t6_period", c - last_fs, 5 + int'(CHK));
        last_fs = c;
      end
    end
    // Random traffic, strobes and occasional resets
    rst();
    for (int i = 0; i < N; i++) src[i] = $urandom;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) vld[i] = $urandom_range(3) != 0;
      step($urandom_range(9) < 7, $urandom_range(99) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
